// File: rtl/beep_scheduler.sv
// -----------------------------------------------------------------------------
// beep_scheduler
//   Parking-sensor tone sequencer. Converts the latest measured distance into a
//   proximity zone and drives the audio codec's phase-increment input with a
//   beep/gap cadence:
//     zone 0 : silent          (far, or no echo)
//     zone 1 : slow beeps      (BEEP_MS on, GAP_SLOW_MS off)
//     zone 2 : fast beeps      (BEEP_MS on, GAP_FAST_MS off)
//     zone 3 : continuous tone (very near)
//   All cadence timing runs off a 1-cycle tick derived from the system clock.
//
// Ports
//   iCLK_18_4     in  1       system clock, all logic on posedge
//   iRST          in  1       synchronous reset, active-high
//   iDist         in  DIST_W  measured distance in cm, 0 = no echo
//   iDist_valid   in  1       one-cycle strobe, iDist valid this cycle
//   iMute         in  1       level, forces silence while cadence keeps running
//   oSound        out 16      phase increment to codec, 0 = silence
//   oZone         out 2       current proximity zone 0..3
//   oBeep_active  out 1       high while the FSM is in TONE or CONT (ignores iMute)
//
// Optional feature
//   BEEP_SCHEDULER_WATCHDOG_EN : when defined, a tick counter cleared by every
//   iDist_valid forces oZone to 0 after TIMEOUT_MS ticks with no strobe, so a
//   stalled range finder cannot leave the tone on. The counter then holds until
//   the next strobe. TIMEOUT_MS exists only in this build.
// -----------------------------------------------------------------------------
module beep_scheduler #(
    parameter int          CLK_HZ      = 18432000,
    parameter int          TICK_HZ     = 1000,
    parameter int          DIST_W      = 9,
    parameter int          NEAR_CM     = 30,
    parameter int          MID_CM      = 80,
    parameter int          FAR_CM      = 150,
    parameter int          BEEP_MS     = 60,
    parameter int          GAP_FAST_MS = 100,
    parameter int          GAP_SLOW_MS = 400,
    parameter logic [15:0] TONE_INC    = 16'd1024
`ifdef BEEP_SCHEDULER_WATCHDOG_EN
    ,
    parameter int          TIMEOUT_MS  = 500
`endif
) (
    input  logic              iCLK_18_4,
    input  logic              iRST,
    input  logic [DIST_W-1:0] iDist,
    input  logic              iDist_valid,
    input  logic              iMute,
    output logic [15:0]       oSound,
    output logic [1:0]        oZone,
    output logic              oBeep_active
);

    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DUR_MAX  = (BEEP_MS > GAP_SLOW_MS) ? BEEP_MS : GAP_SLOW_MS;
    localparam int DUR_W    = $clog2(DUR_MAX + 1);

    localparam logic [PRE_W-1:0] PRE_LAST      = PRE_W'(PRESCALE - 1);
    localparam logic [DUR_W-1:0] BEEP_LAST     = DUR_W'(BEEP_MS - 1);
    localparam logic [DUR_W-1:0] GAP_FAST_LAST = DUR_W'(GAP_FAST_MS - 1);
    localparam logic [DUR_W-1:0] GAP_SLOW_LAST = DUR_W'(GAP_SLOW_MS - 1);

    typedef enum logic [1:0] {
        ST_SILENT = 2'd0,
        ST_TONE   = 2'd1,
        ST_GAP    = 2'd2,
        ST_CONT   = 2'd3
    } state_t;

    logic [PRE_W-1:0] pre_reg;
    logic             tick;
    logic [1:0]       zone_reg;
    logic [1:0]       zone_meas;
    state_t           state_reg, state_next;
    logic [DUR_W-1:0] dur_reg, dur_next;
    logic [DUR_W-1:0] dur_inc;
    logic [DUR_W-1:0] gap_last;
    logic [15:0]      sound_reg;

    // ---------------------------------------------------------------- prescaler
    assign tick = (pre_reg == PRE_LAST);

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            pre_reg <= '0;
        end else if (tick) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------ zone mapping
    // Thresholds are compared on a zero-extended copy so a threshold larger
    // than the distance range still behaves as "always below".
    logic [31:0] dist_ext;
    assign dist_ext = 32'(iDist);

    always_comb begin
        zone_meas = 2'd0;
        if (dist_ext == 32'd0) begin
            zone_meas = 2'd0;
        end else if (dist_ext < 32'(NEAR_CM)) begin
            zone_meas = 2'd3;
        end else if (dist_ext < 32'(MID_CM)) begin
            zone_meas = 2'd2;
        end else if (dist_ext < 32'(FAR_CM)) begin
            zone_meas = 2'd1;
        end
    end

`ifdef BEEP_SCHEDULER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_MS + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_MS);

    logic [WD_W-1:0] wd_cnt_reg;

    // The counter parks at WD_LIMIT so the forced zone 0 is applied only once
    // and a later strobe restores normal operation.
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            zone_reg   <= 2'd0;
            wd_cnt_reg <= '0;
        end else if (iDist_valid) begin
            zone_reg   <= zone_meas;
            wd_cnt_reg <= '0;
        end else if (tick && (wd_cnt_reg != WD_LIMIT)) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
            if (wd_cnt_reg == WD_LIMIT - 1'b1) begin
                zone_reg <= 2'd0;
            end
        end
    end
`else
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            zone_reg <= 2'd0;
        end else if (iDist_valid) begin
            zone_reg <= zone_meas;
        end
    end
`endif

    // ------------------------------------------------------------------- FSM
    assign dur_inc  = (dur_reg == {DUR_W{1'b1}}) ? dur_reg : dur_reg + 1'b1;
    // Re-evaluated every tick so moving closer shortens a gap already running.
    assign gap_last = (zone_reg == 2'd2) ? GAP_FAST_LAST : GAP_SLOW_LAST;

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            state_reg <= ST_SILENT;
            dur_reg   <= '0;
        end else begin
            state_reg <= state_next;
            dur_reg   <= dur_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        dur_next   = dur_reg;
        if (tick) begin
            if (zone_reg == 2'd0) begin
                state_next = ST_SILENT;
                dur_next   = '0;
            end else if (zone_reg == 2'd3) begin
                state_next = ST_CONT;
                dur_next   = '0;
            end else begin
                // zone 1 or 2: beeping cadence
                case (state_reg)
                    ST_SILENT: begin
                        state_next = ST_TONE;
                        dur_next   = '0;
                    end
                    ST_CONT: begin
                        state_next = ST_GAP;
                        dur_next   = '0;
                    end
                    ST_TONE: begin
                        if (dur_reg == BEEP_LAST) begin
                            state_next = ST_GAP;
                            dur_next   = '0;
                        end else begin
                            dur_next = dur_inc;
                        end
                    end
                    ST_GAP: begin
                        if (dur_reg >= gap_last) begin
                            state_next = ST_TONE;
                            dur_next   = '0;
                        end else begin
                            dur_next = dur_inc;
                        end
                    end
                    default: begin
                        state_next = ST_SILENT;
                        dur_next   = '0;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    // Looks at the next state so the tone starts/stops on the same edge as the
    // state change; iMute is sampled every cycle, not just on ticks.
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            sound_reg <= '0;
        end else if (((state_next == ST_TONE) || (state_next == ST_CONT)) && !iMute) begin
            sound_reg <= TONE_INC;
        end else begin
            sound_reg <= '0;
        end
    end

    assign oSound       = sound_reg;
    assign oZone        = zone_reg;
    assign oBeep_active = (state_reg == ST_TONE) || (state_reg == ST_CONT);

endmodule
